// File: rtl/ula_multiciclo_pkg.sv
// Shared opcode constants and FSM state encoding for the multicycle ALU.
package ula_multiciclo_pkg;

  localparam logic [3:0] ULA_ADD  = 4'd0;
  localparam logic [3:0] ULA_SUB  = 4'd1;
  localparam logic [3:0] ULA_MULT = 4'd2;
  localparam logic [3:0] ULA_DIV  = 4'd3;
  localparam logic [3:0] ULA_AND  = 4'd4;
  localparam logic [3:0] ULA_OR   = 4'd5;
  localparam logic [3:0] ULA_XOR  = 4'd6;
  localparam logic [3:0] ULA_NOT  = 4'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/ula_muldiv.sv
// Iterative datapath: shift-add multiplier and restoring divider, one step per cycle.
// Both engines load and step together; the controller picks the relevant outputs.
module ula_muldiv #(
  parameter int WIDTH = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load_i,
  input  logic               step_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic [2*WIDTH-1:0] product_o,
  output logic [WIDTH-1:0]   quotient_o,
  output logic [WIDTH-1:0]   remainder_o
);

  logic [2*WIDTH-1:0] acc_q, mcand_q;
  logic [WIDTH-1:0]   mplier_q, rem_q, quo_q, dvs_q;
  logic [WIDTH:0]     rem_shift, rem_diff;
  logic               fits;

  // Remainder stays below the divisor, so the shifted value fits in WIDTH+1 bits.
  assign rem_shift = {rem_q, quo_q[WIDTH-1]};
  assign fits      = (rem_shift >= {1'b0, dvs_q});
  assign rem_diff  = rem_shift - {1'b0, dvs_q};

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
    end else if (load_i) begin
      acc_q    <= '0;
      mcand_q  <= {{WIDTH{1'b0}}, a_i};
      mplier_q <= b_i;
      rem_q    <= '0;
      quo_q    <= a_i;
      dvs_q    <= b_i;
    end else if (step_i) begin
      if (mplier_q[0]) acc_q <= acc_q + mcand_q;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      rem_q    <= fits ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
      quo_q    <= {quo_q[WIDTH-2:0], fits};
    end
  end

  assign product_o   = acc_q;
  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;

endmodule

// File: rtl/ula_multiciclo.sv
// Multicycle ALU: single-cycle logic/add/sub, iterative MULT/DIV via ula_muldiv.
// state | meaning: IDLE waiting for start | EXEC operation running | DONE result valid, done pulse
module ula_multiciclo
  import ula_multiciclo_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [3:0]         opcode,
  input  logic [WIDTH-1:0]   operando1,
  input  logic [WIDTH-1:0]   operando2,
  output logic [2*WIDTH-1:0] result,
  output logic               busy,
  output logic               done,
  output logic               zero,
  output logic               erro
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t             state_q;
  logic [3:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] result_q, res_d;
  logic               busy_q, done_q, zero_q, erro_q, erro_d;
  logic               accept, iterative;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   quotient, remainder;

  assign accept    = start && (state_q != S_EXEC);
  // Divide-by-zero skips the iterations and completes like a simple op.
  assign iterative = (opcode == ULA_MULT) || ((opcode == ULA_DIV) && (operando2 != '0));

  ula_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clock       (clock),
    .reset       (reset),
    .load_i      (accept),
    .step_i      ((state_q == S_EXEC) && (cnt_q != '0)),
    .a_i         (operando1),
    .b_i         (operando2),
    .product_o   (product),
    .quotient_o  (quotient),
    .remainder_o (remainder)
  );

  always_comb begin
    res_d  = '0;
    erro_d = 1'b0;
    case (op_q)
      ULA_ADD:  res_d = {{WIDTH{1'b0}}, a_q} + {{WIDTH{1'b0}}, b_q};
      ULA_SUB:  res_d = {{WIDTH{1'b0}}, a_q} - {{WIDTH{1'b0}}, b_q};
      ULA_MULT: res_d = product;
      ULA_DIV: begin
        if (b_q == '0) begin
          res_d  = {a_q, {WIDTH{1'b1}}};
          erro_d = 1'b1;
        end else begin
          res_d = {remainder, quotient};
        end
      end
      ULA_AND:  res_d = {{WIDTH{1'b0}}, a_q & b_q};
      ULA_OR:   res_d = {{WIDTH{1'b0}}, a_q | b_q};
      ULA_XOR:  res_d = {{WIDTH{1'b0}}, a_q ^ b_q};
      ULA_NOT:  res_d = {{WIDTH{1'b0}}, ~a_q};
      default:  erro_d = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      zero_q   <= 1'b0;
      erro_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (accept) begin
            state_q <= S_EXEC;
            busy_q  <= 1'b1;
            op_q    <= opcode;
            a_q     <= operando1;
            b_q     <= operando2;
            cnt_q   <= iterative ? CW'(WIDTH) : '0;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_EXEC: begin
          if (cnt_q == '0) begin
            state_q  <= S_DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            result_q <= res_d;
            zero_q   <= (res_d == '0);
            erro_q   <= erro_d;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign result = result_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign zero   = zero_q;
  assign erro   = erro_q;

endmodule

// File: tb/tb_ula_multiciclo.sv
// Bench for ula_multiciclo: directed cases plus random ops against an arithmetic reference model.
module tb_ula_multiciclo;
  import ula_multiciclo_pkg::*;

  localparam int W = 4;

  logic           clock = 1'b0;
  logic           reset, start;
  logic [3:0]     opcode;
  logic [W-1:0]   operando1, operando2;
  logic [2*W-1:0] result;
  logic           busy, done, zero, erro;

  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  ula_multiciclo #(.WIDTH(W)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .opcode    (opcode),
    .operando1 (operando1),
    .operando2 (operando2),
    .result    (result),
    .busy      (busy),
    .done      (done),
    .zero      (zero),
    .erro      (erro)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Expected result, error flag and edges from accept to done.
  function automatic void model(input logic [3:0] op, input int a, input int b,
                                output int res, output int er, output int lat);
    int m    = 1 << (2 * W);
    int mask = (1 << W) - 1;
    res = 0; er = 0; lat = 1;
    case (op)
      ULA_ADD:  res = a + b;
      ULA_SUB:  res = (a - b + m) % m;
      ULA_MULT: begin res = a * b; lat = W + 1; end
      ULA_DIV: begin
        if (b == 0) begin
          res = (a << W) | mask;
          er  = 1;
        end else begin
          res = ((a % b) << W) | (a / b);
          lat = W + 1;
        end
      end
      ULA_AND:  res = a & b;
      ULA_OR:   res = a | b;
      ULA_XOR:  res = a ^ b;
      ULA_NOT:  res = (~a) & mask;
      default:  er = 1;
    endcase
  endfunction

  task automatic do_op(input logic [3:0] op, input int a, input int b, input bit poke);
    int res, er, lat_exp, lat;
    model(op, a, b, res, er, lat_exp);
    @(negedge clock);
    start = 1'b1; opcode = op; operando1 = a[W-1:0]; operando2 = b[W-1:0];
    @(negedge clock);
    start = 1'b0;
    opcode = 4'($urandom_range(0, 15));
    operando1 = W'($urandom);
    operando2 = W'($urandom);
    chk("busy_after_accept", busy, 1);
    chk("done_early", done, 0);
    lat = 0;
    do begin
      if (poke && lat == 1) begin start = 1'b1; opcode = ULA_ADD; end
      if (poke && lat == 2) start = 1'b0;
      @(negedge clock);
      lat++;
      if (!done && lat < lat_exp) chk("busy_exec", busy, 1);
    end while (!done && lat < 40);
    chk("latency", lat, lat_exp);
    chk("result", int'(result), res);
    chk("zero", zero, (res == 0) ? 1 : 0);
    chk("erro", erro, er);
    chk("busy_with_done", busy, 0);
    @(negedge clock);
    chk("done_pulse", done, 0);
    chk("result_held", int'(result), res);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; opcode = '0; operando1 = '0; operando2 = '0;
    repeat (2) @(negedge clock);
    chk("rst_result", int'(result), 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_zero", zero, 0);
    chk("rst_erro", erro, 0);
    reset = 1'b0;

    do_op(ULA_ADD, 9, 8, 1'b0);
    do_op(ULA_MULT, 15, 15, 1'b1);
    do_op(ULA_DIV, 13, 4, 1'b0);
    do_op(ULA_DIV, 7, 0, 1'b0);
    do_op(ULA_SUB, 3, 5, 1'b0);
    do_op(ULA_XOR, 5, 5, 1'b0);
    do_op(ULA_NOT, 6, 0, 1'b0);
    do_op(4'hC, 3, 3, 1'b0);

    // Reset in the middle of a multiply aborts it without a done pulse.
    @(negedge clock);
    start = 1'b1; opcode = ULA_MULT; operando1 = 4'd15; operando2 = 4'd15;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("abort_result", int'(result), 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_zero", zero, 0);
    chk("abort_erro", erro, 0);
    reset = 1'b0;
    for (int i = 0; i < W + 3; i++) begin
      @(negedge clock);
      chk("abort_no_done", done, 0);
    end
    do_op(ULA_ADD, 1, 1, 1'b0);

    // Start held high: accepted again from DONE, done every second cycle.
    @(negedge clock);
    start = 1'b1; opcode = ULA_ADD; operando1 = 4'd1; operando2 = 4'd2;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clock);
      chk("b2b_done", done, (i % 2 == 0) ? 1 : 0);
      chk("b2b_busy", busy, (i % 2 == 0) ? 0 : 1);
      if (done) chk("b2b_result", int'(result), 3);
    end
    start = 1'b0;
    repeat (2) @(negedge clock);

    for (int i = 0; i < 150; i++) begin
      int a, b;
      a = int'($urandom_range(0, (1 << W) - 1));
      b = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, (1 << W) - 1));
      do_op(4'($urandom_range(0, 15)), a, b, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
